// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
// card_pkg : shared types, sizes and LFSR taps for the card shoe
// Revision : 1.0
// ============================================================================
package card_pkg;

  localparam int CARD_W    = 6;
  localparam int RANK_W    = 4;
  localparam int SUIT_W    = 2;
  localparam int LFSR_W    = 16;
  localparam int DECK_SIZE = 52;

  typedef logic [CARD_W-1:0] card_idx_t;

  localparam card_idx_t LAST_IDX  = card_idx_t'(DECK_SIZE - 1);
  localparam card_idx_t DECK_FULL = card_idx_t'(DECK_SIZE);

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_SHUFFLE = 2'd1,
    S_READY   = 2'd2
  } shoe_state_e;

  function automatic logic [SUIT_W-1:0] card_suit(input card_idx_t k);
    if (k >= card_idx_t'(39)) return 2'd3;
    if (k >= card_idx_t'(26)) return 2'd2;
    if (k >= card_idx_t'(13)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [RANK_W-1:0] card_rank(input card_idx_t k);
    return RANK_W'(k - card_idx_t'(13 * card_suit(k))) + RANK_W'(1);
  endfunction

endpackage : card_pkg
`default_nettype wire

// File: rtl/card_lfsr.sv
`default_nettype none
// ============================================================================
// card_lfsr : free-running 16-bit Fibonacci LFSR supplying shuffle indices
// Revision  : 1.0
// ============================================================================
module card_lfsr
  import card_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [CARD_W-1:0] o_rand
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_rand = lfsr_q[CARD_W-1:0];

endmodule : card_lfsr
`default_nettype wire

// File: rtl/card_shoe.sv
`default_nettype none
// ============================================================================
// card_shoe : 52-card deck that initialises, Fisher-Yates shuffles and deals
// Revision  : 1.0
// ============================================================================
module card_shoe
  import card_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter bit                SHUFFLE_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_drawRequest,
  input  logic              i_shuffleRequest,
  output logic              o_ready,
  output logic              o_cardValid,
  output logic [RANK_W-1:0] o_cardRank,
  output logic [SUIT_W-1:0] o_cardSuit,
  output logic [CARD_W-1:0] o_cardsRemaining,
  output logic              o_deckEmpty
);

  shoe_state_e       state_q, state_d;
  card_idx_t         wr_idx_q, wr_idx_d;
  card_idx_t         shuf_i_q, shuf_i_d;
  card_idx_t         ptr_q, ptr_d;
  card_idx_t         remaining_q, remaining_d;
  logic              valid_q, valid_d;
  logic [RANK_W-1:0] rank_q, rank_d;
  logic [SUIT_W-1:0] suit_q, suit_d;

  logic              init_wr;
  logic              swap_en;
  card_idx_t         rand_j;
  card_idx_t         deck_q [DECK_SIZE];

  card_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_rand  (rand_j)
  );

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    shuf_i_d    = shuf_i_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    valid_d     = 1'b0;
    rank_d      = rank_q;
    suit_d      = suit_q;
    init_wr     = 1'b0;
    swap_en     = 1'b0;

    // A fresh-deck request overrides everything, including a same-cycle draw
    if (i_shuffleRequest) begin
      state_d     = S_INIT;
      wr_idx_d    = '0;
      ptr_d       = '0;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          init_wr = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            shuf_i_d = LAST_IDX;
            ptr_d    = '0;
            if (SHUFFLE_EN) begin
              state_d = S_SHUFFLE;
            end else begin
              state_d     = S_READY;
              remaining_d = DECK_FULL;
            end
          end else begin
            wr_idx_d = wr_idx_q + card_idx_t'(1);
          end
        end
        S_SHUFFLE: begin
          // Out-of-range draws are simply retried on the next LFSR value
          if (rand_j <= shuf_i_q) begin
            swap_en = 1'b1;
            if (shuf_i_q == card_idx_t'(1)) begin
              state_d     = S_READY;
              remaining_d = DECK_FULL;
              ptr_d       = '0;
            end else begin
              shuf_i_d = shuf_i_q - card_idx_t'(1);
            end
          end
        end
        S_READY: begin
          if (i_drawRequest && (remaining_q != '0)) begin
            valid_d     = 1'b1;
            rank_d      = card_rank(deck_q[ptr_q]);
            suit_d      = card_suit(deck_q[ptr_q]);
            ptr_d       = ptr_q + card_idx_t'(1);
            remaining_d = remaining_q - card_idx_t'(1);
          end
        end
        default: begin
          state_d  = S_INIT;
          wr_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_INIT;
      wr_idx_q    <= '0;
      shuf_i_q    <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      rank_q      <= '0;
      suit_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      shuf_i_q    <= shuf_i_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      rank_q      <= rank_d;
      suit_q      <= suit_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (init_wr) begin
        deck_q[wr_idx_q] <= wr_idx_q;
      end else if (swap_en) begin
        deck_q[shuf_i_q] <= deck_q[rand_j];
        deck_q[rand_j]   <= deck_q[shuf_i_q];
      end
    end
  end

  assign o_ready          = (state_q == S_READY) && (remaining_q != '0);
  assign o_cardValid      = valid_q;
  assign o_cardRank       = rank_q;
  assign o_cardSuit       = suit_q;
  assign o_cardsRemaining = remaining_q;
  assign o_deckEmpty      = (state_q == S_READY) && (remaining_q == '0);

endmodule : card_shoe
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ============================================================================
// tb_card_shoe : directed scoreboard bench for an ordered and a shuffled shoe
// Revision     : 1.0
// ============================================================================
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       rst0, draw0, shuf0, ready0, valid0, empty0;
  logic [3:0] rank0;
  logic [1:0] suit0;
  logic [5:0] rem0;
  logic       rst1, draw1, shuf1, ready1, valid1, empty1;
  logic [3:0] rank1;
  logic [1:0] suit1;
  logic [5:0] rem1;

  int checks = 0;
  int errors = 0;

  int exp0_q[$];
  int exp1_q[$];
  int got1_q[$];
  int run1_q[$];
  int perm[52];

  always #5 clk = ~clk;

  card_shoe #(.LFSR_SEED(16'hACE1), .SHUFFLE_EN(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst0), .i_drawRequest(draw0), .i_shuffleRequest(shuf0),
    .o_ready(ready0), .o_cardValid(valid0), .o_cardRank(rank0), .o_cardSuit(suit0),
    .o_cardsRemaining(rem0), .o_deckEmpty(empty0)
  );

  card_shoe #(.LFSR_SEED(16'hACE1), .SHUFFLE_EN(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_drawRequest(draw1), .i_shuffleRequest(shuf1),
    .o_ready(ready1), .o_cardValid(valid1), .o_cardRank(rank1), .o_cardSuit(suit1),
    .o_cardsRemaining(rem1), .o_deckEmpty(empty1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_card(input int k);
    return ((k % 13) + 1) * 4 + (k / 13);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference Fisher-Yates: 52 init cycles advance the LFSR before the first j
  task automatic build_perm();
    logic [15:0] l;
    int j;
    int tmp;
    for (int k = 0; k < 52; k++) perm[k] = k;
    l = 16'hACE1;
    repeat (52) l = lfsr_next(l);
    for (int i = 51; i >= 1; i--) begin
      j = int'(l[5:0]);
      l = lfsr_next(l);
      while (j > i) begin
        j = int'(l[5:0]);
        l = lfsr_next(l);
      end
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
  endtask

  always @(negedge clk) begin
    if (valid0) begin
      checks++;
      assert (exp0_q.size() != 0) else begin
        errors++;
        $error("FAIL strobe0: unexpected strobe rank %0d suit %0d, expected none", rank0, suit0);
      end
      if (exp0_q.size() != 0) check("card0", int'(rank0) * 4 + int'(suit0), exp_card(exp0_q.pop_front()));
    end
    if (valid1) begin
      got1_q.push_back(int'(suit1) * 13 + int'(rank1) - 1);
      checks++;
      assert (exp1_q.size() != 0) else begin
        errors++;
        $error("FAIL strobe1: unexpected strobe rank %0d suit %0d, expected none", rank1, suit1);
      end
      if (exp1_q.size() != 0) check("card1", int'(rank1) * 4 + int'(suit1), exp_card(exp1_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int sel);
    for (int c = 0; c < 5000; c++) begin
      if ((sel == 0) ? ready0 : ready1) break;
      tick();
    end
    check("wait_ready", int'((sel == 0) ? ready0 : ready1), 1);
  endtask

  task automatic draw_shuffled(input int n);
    for (int k = 0; k < n; k++) begin
      exp1_q.push_back(perm[k]);
      draw1 = 1'b1;
      tick();
    end
    draw1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [51:0] seen;
    int dup;
    int diff;
    rst0 = 1'b1; draw0 = 1'b0; shuf0 = 1'b0;
    rst1 = 1'b1; draw1 = 1'b0; shuf1 = 1'b0;
    build_perm();
    tick();
    tick();

    check("rst_ready",  int'(ready0), 0);
    check("rst_valid",  int'(valid0), 0);
    check("rst_rank",   int'(rank0),  0);
    check("rst_suit",   int'(suit0),  0);
    check("rst_remain", int'(rem0),   0);
    check("rst_empty",  int'(empty0), 0);

    // Ordered deck: first three cards are A, 2, 3 of suit 0
    rst0 = 1'b0;
    wait_ready(0);
    check("full_remain", int'(rem0), 52);
    check("full_empty",  int'(empty0), 0);
    for (int k = 0; k < 3; k++) begin
      exp0_q.push_back(k);
      draw0 = 1'b1;
      tick();
      if (k == 0) check("strobe_latency", int'(valid0), 1);
    end
    draw0 = 1'b0;
    tick();
    tick();
    check("remain_49",   int'(rem0), 49);
    check("sb0_drained", exp0_q.size(), 0);
    check("hold_valid",  int'(valid0), 0);
    check("hold_card",   int'(rank0) * 4 + int'(suit0), exp_card(2));

    // Draw and shuffle together: shuffle wins
    draw0 = 1'b1;
    shuf0 = 1'b1;
    tick();
    draw0 = 1'b0;
    shuf0 = 1'b0;
    check("coll_valid",  int'(valid0), 0);
    check("coll_ready",  int'(ready0), 0);
    check("coll_remain", int'(rem0),   0);
    wait_ready(0);
    check("reinit_remain", int'(rem0), 52);

    // Whole deck back-to-back, then an ignored 53rd draw
    for (int k = 0; k < 52; k++) begin
      exp0_q.push_back(k);
      draw0 = 1'b1;
      tick();
    end
    draw0 = 1'b0;
    tick();
    check("empty_flag",   int'(empty0), 1);
    check("empty_ready",  int'(ready0), 0);
    check("empty_remain", int'(rem0),   0);
    check("last_card",    int'(rank0) * 4 + int'(suit0), 13 * 4 + 3);
    draw0 = 1'b1;
    tick();
    draw0 = 1'b0;
    tick();
    tick();
    check("extra_remain", int'(rem0), 0);
    check("sb0_all",      exp0_q.size(), 0);

    // Shuffled deck from reset matches the reference permutation
    rst1 = 1'b0;
    wait_ready(1);
    check("shuf_remain", int'(rem1), 52);
    draw_shuffled(52);
    check("sb1_run1", exp1_q.size(), 0);
    seen = '0;
    dup  = 0;
    foreach (got1_q[n]) begin
      if (got1_q[n] < 0 || got1_q[n] > 51 || seen[got1_q[n]]) dup++;
      else seen[got1_q[n]] = 1'b1;
    end
    check("perm_dup",   dup, 0);
    check("perm_count", got1_q.size(), 52);
    run1_q = got1_q;
    got1_q.delete();

    // Same seed and timing reproduces the sequence
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    wait_ready(1);
    draw_shuffled(52);
    diff = 0;
    foreach (got1_q[n]) if (n >= run1_q.size() || got1_q[n] != run1_q[n]) diff++;
    check("rerun_diff",  diff, 0);
    check("rerun_count", got1_q.size(), 52);

    // Reset on the 20th shuffle cycle restarts cleanly
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    repeat (71) tick();
    check("midshuf_ready", int'(ready1), 0);
    rst1 = 1'b1;
    tick();
    check("midshuf_lfsr",   int'(dut1.u_lfsr.lfsr_q), 16'hACE1);
    check("midshuf_valid",  int'(valid1), 0);
    check("midshuf_remain", int'(rem1),   0);
    rst1 = 1'b0;
    wait_ready(1);
    draw_shuffled(10);
    check("sb1_midshuf", exp1_q.size(), 0);

    // Collision in the shuffled shoe, then recovery to a full deck
    draw1 = 1'b1;
    shuf1 = 1'b1;
    tick();
    draw1 = 1'b0;
    shuf1 = 1'b0;
    check("coll1_valid", int'(valid1), 0);
    check("coll1_ready", int'(ready1), 0);
    wait_ready(1);
    check("coll1_remain", int'(rem1), 52);
    tick();
    check("sb1_final", exp1_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_card_shoe
`default_nettype wire

// File: doc/card_shoe.md
CARD_SHOE -- requirements
Module: card_shoe

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, the shuffle LFSR value loaded at reset (nonzero).
REQ-002 SHALL have parameter SHUFFLE_EN, default 1; 0 skips shuffling so the deck stays ordered (for test).
REQ-003 SHALL have port i_clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_drawRequest  input  1  one-cycle pulse requesting the next card.
REQ-006 SHALL have port i_shuffleRequest  input  1  one-cycle pulse requesting a fresh 52-card deck.
REQ-007 SHALL have port o_ready  output  1  high when a draw will be accepted.
REQ-008 SHALL have port o_cardValid  output  1  one-cycle strobe qualifying o_cardRank and o_cardSuit.
REQ-009 SHALL have port o_cardRank  output  4  card rank 1..13 (1 = ace, 11..13 = J, Q, K).
REQ-010 SHALL have port o_cardSuit  output  2  card suit 0..3.
REQ-011 SHALL have port o_cardsRemaining  output  6  undealt cards, 0..52.
REQ-012 SHALL have port o_deckEmpty  output  1  high when o_cardsRemaining == 0 and state is S_READY.

Function
REQ-013 SHALL store 52 six-bit card indices k, with rank = (k mod 13)+1 and suit = k div 13.
REQ-014 SHALL implement states S_INIT, S_SHUFFLE, S_READY.
REQ-015 S_INIT SHALL write slot k = k for k = 0..51, one slot per cycle (52 cycles), then go to S_SHUFFLE if SHUFFLE_EN else S_READY.
REQ-016 S_SHUFFLE SHALL perform Fisher-Yates for i = 51 down to 1: draw j from LFSR bits [5:0].
REQ-017 In S_SHUFFLE, j > i SHALL be rejected and retried the next cycle; accepted j SHALL swap slots i and j in one cycle.
REQ-018 After the i = 1 swap, the block SHALL go to S_READY with o_cardsRemaining = 52 and the draw pointer = 0.
REQ-019 The LFSR SHALL use x^16+x^14+x^13+x^11+1, Fibonacci form, and advance every cycle in every state.
REQ-020 o_ready SHALL be high only in S_READY with o_cardsRemaining > 0.
REQ-021 A draw accepted at edge N SHALL raise o_cardValid for exactly the cycle after N, carrying slot[pointer], increment the pointer and decrement o_cardsRemaining.
REQ-022 Back-to-back draws on consecutive cycles SHALL each be served, one card per cycle.
REQ-023 A draw while o_ready is low SHALL be ignored: no strobe and no counter change.
REQ-024 i_shuffleRequest in any state SHALL return the block to S_INIT, set o_cardsRemaining to 0, and drop o_ready the next cycle.
REQ-025 If draw and shuffle are requested in the same cycle, shuffle SHALL win and no card is issued.
REQ-026 o_cardRank and o_cardSuit SHALL hold their last value while o_cardValid is low.

Reset
REQ-027 On i_reset: state = S_INIT, write index 0, LFSR = LFSR_SEED, pointer = 0, o_cardsRemaining = 0, o_cardValid = 0, o_ready = 0, o_cardRank = 0, o_cardSuit = 0, o_deckEmpty = 0.
REQ-028 Reset asserted mid-S_INIT, mid-S_SHUFFLE or mid-draw SHALL abort the operation and restart from REQ-027 with no o_cardValid strobe.

Structure
REQ-029 Shared package card_pkg SHALL hold: DECK_SIZE = 52, the card index type, rank and suit widths, the shoe state enum, and the LFSR taps.
REQ-030 The LFSR SHALL be the sub-module card_lfsr, with seed parameter and synchronous reset.
REQ-031 Deck storage SHALL be a 52-entry register array inside card_shoe.

Verification
REQ-032 SHUFFLE_EN=0, reset, wait for o_ready, draw 3 -> strobes give (rank 1, suit 0), (2, 0), (3, 0); o_cardsRemaining = 49.
REQ-033 SHUFFLE_EN=0, draw 52 back-to-back -> 52 consecutive strobes, last one (13, 3); then o_deckEmpty = 1, o_ready = 0; a 53rd draw gives no strobe.
REQ-034 SHUFFLE_EN=1, seed default, draw 52 -> every index 0..51 appears exactly once; a rerun with the same seed and timing gives an identical sequence.
REQ-035 In S_READY, i_drawRequest and i_shuffleRequest in the same cycle -> no o_cardValid; o_ready = 0 next cycle; o_ready returns after re-init and shuffle with o_cardsRemaining = 52.
REQ-036 i_reset pulsed for 1 cycle at the 20th S_SHUFFLE cycle -> no strobe; LFSR = 16'hACE1; o_ready returns with a sequence identical to the REQ-034 run.
